// File: rtl/smc_seq.sv
// smc_seq: serial MOSFET evaluator/ranker. One shared I/gm unit and an insertion-sorted
// ranker, with one weighted result per group of N_DEV descriptors. Optional gm path: SMC_SEQ_GM_EN.
module smc_seq #(
    parameter int N_DEV = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] mode,
    input  logic [2:0] W,
    input  logic [2:0] V_GS,
    input  logic [2:0] V_DS,
    output logic       out_valid,
    output logic [7:0] out_n,
    output logic       busy
);
    localparam int CW = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sel_q, sel_d;
    logic [2:0]      w_q, w_d, vgs_q, vgs_d, vds_q, vds_d;
    logic            acc_v_q, acc_v_d, acc_last_q, acc_last_d;
    logic [6:0]      ev_q, ev_d;
    logic            ev_v_q, ev_v_d, ev_last_q, ev_last_d;
    logic [6:0]      rank_q [N_DEV];
    logic [6:0]      rank_d [N_DEV];
    logic [N_DEV-1:0] gt;
    logic            abort, clr, ins;
    logic [2:0]      v;
    logic [8:0]      i_num;
    logic [6:0]      sa, sb, sc;
    logic [9:0]      wsum;

`ifdef SMC_SEQ_GM_EN
    logic gm_q, gm_d;
    logic [8:0] g_num;
`else
    logic unused_mode0;
    assign unused_mode0 = mode[0];
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        w_d        = w_q;
        vgs_d      = vgs_q;
        vds_d      = vds_q;
        acc_v_d    = 1'b0;
        acc_last_d = 1'b0;
        abort      = 1'b0;
`ifdef SMC_SEQ_GM_EN
        gm_d       = gm_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = LOAD;
                cnt_d   = CW'(1);
                sel_d   = mode[1];
`ifdef SMC_SEQ_GM_EN
                gm_d    = mode[0];
`endif
                acc_v_d = 1'b1;
                w_d = W; vgs_d = V_GS; vds_d = V_DS;
            end
            LOAD: if (in_valid) begin
                acc_v_d = 1'b1;
                w_d = W; vgs_d = V_GS; vds_d = V_DS;
                if (cnt_q == CW'(N_DEV - 1)) begin
                    acc_last_d = 1'b1;
                    state_d    = DRAIN;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                // A short burst kills the group, including anything still in the pipeline.
                abort   = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end
            DRAIN: if (ev_v_q && ev_last_q) state_d = OUT;
            OUT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shared evaluator; V_GS=0 would wrap v to 7, so it is forced to zero.
    always_comb begin
        v     = vgs_q - 3'd1;
        i_num = '0;
`ifdef SMC_SEQ_GM_EN
        g_num = '0;
`endif
        if (vgs_q != 3'd0) begin
            if (v <= vds_q) begin
                i_num = 9'(w_q) * 9'(v) * 9'(v);
`ifdef SMC_SEQ_GM_EN
                g_num = 9'(w_q) * 9'(v) * 9'd2;
`endif
            end else begin
                i_num = 9'(w_q) * (9'(v) * 9'(vds_q) * 9'd2 - 9'(vds_q) * 9'(vds_q));
`ifdef SMC_SEQ_GM_EN
                g_num = 9'(w_q) * 9'(vds_q) * 9'd2;
`endif
            end
        end
`ifdef SMC_SEQ_GM_EN
        ev_d = gm_q ? 7'(g_num / 9'd3) : 7'(i_num / 9'd3);
`else
        ev_d = 7'(i_num / 9'd3);
`endif
        ev_v_d    = acc_v_q && !abort;
        ev_last_d = acc_last_q;
    end

    assign clr = abort || (state_q == OUT);
    assign ins = ev_v_q && !clr;

    genvar gi;
    generate
        for (gi = 0; gi < N_DEV; gi++) begin : g_rank
            assign gt[gi] = ev_q > rank_q[gi];
            if (gi == 0) begin : g_head
                assign rank_d[gi] = clr ? 7'd0 : ((ins && gt[gi]) ? ev_q : rank_q[gi]);
            end else begin : g_body
                assign rank_d[gi] = clr ? 7'd0 :
                                    ((ins && gt[gi]) ? (gt[gi-1] ? rank_q[gi-1] : ev_q) : rank_q[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= 1'b0;
            w_q        <= '0;
            vgs_q      <= '0;
            vds_q      <= '0;
            acc_v_q    <= 1'b0;
            acc_last_q <= 1'b0;
            ev_q       <= '0;
            ev_v_q     <= 1'b0;
            ev_last_q  <= 1'b0;
`ifdef SMC_SEQ_GM_EN
            gm_q       <= 1'b0;
`endif
            for (int i = 0; i < N_DEV; i++) rank_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            w_q        <= w_d;
            vgs_q      <= vgs_d;
            vds_q      <= vds_d;
            acc_v_q    <= acc_v_d;
            acc_last_q <= acc_last_d;
            ev_q       <= ev_d;
            ev_v_q     <= ev_v_d;
            ev_last_q  <= ev_last_d;
`ifdef SMC_SEQ_GM_EN
            gm_q       <= gm_d;
`endif
            for (int i = 0; i < N_DEV; i++) rank_q[i] <= rank_d[i];
        end
    end

    assign sa   = sel_q ? rank_q[0] : rank_q[N_DEV-3];
    assign sb   = sel_q ? rank_q[1] : rank_q[N_DEV-2];
    assign sc   = sel_q ? rank_q[2] : rank_q[N_DEV-1];
    assign wsum = 10'(sa) * 10'd3 + 10'(sb) * 10'd4 + 10'(sc) * 10'd5;

    assign out_valid = (state_q == OUT);
    assign out_n     = out_valid ? 8'(wsum / 10'd12) : 8'd0;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_smc_seq.sv
// Randomized + directed bench for smc_seq against a sort-based reference model.
module tb_smc_seq;
    localparam int N = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] W = '0, V_GS = '0, V_DS = '0;
    logic       out_valid;
    logic [7:0] out_n;
    logic       busy;

    int n_chk = 0;
    int n_pass = 0;
    int tw[N], tg[N], td[N];

    smc_seq #(.N_DEV(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
        .W(W), .V_GS(V_GS), .V_DS(V_DS),
        .out_valid(out_valid), .out_n(out_n), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic bit gm_sel(input logic [1:0] m);
`ifdef SMC_SEQ_GM_EN
        return m[0];
`else
        return 1'b0;
`endif
    endfunction

    function automatic int f_eval(input int w, input int vgs, input int vds, input bit gm);
        int v;
        v = vgs - 1;
        if (v <= 0) return 0;
        if (v <= vds) return gm ? (2 * w * v) / 3 : (w * v * v) / 3;
        return gm ? (2 * w * vds) / 3 : (w * (2 * v * vds - vds * vds)) / 3;
    endfunction

    function automatic int f_out(input int vals[N], input bit largest);
        int q[$];
        int a, b, c;
        for (int i = 0; i < N; i++) q.push_back(vals[i]);
        q.sort();
        if (largest) begin a = q[N-1]; b = q[N-2]; c = q[N-3]; end
        else         begin a = q[2];   b = q[1];   c = q[0];   end
        return (3 * a + 4 * b + 5 * c) / 12;
    endfunction

    task automatic run_group(input logic [1:0] m, input bit noise, input string tag);
        int vals[N];
        int expv;
        for (int i = 0; i < N; i++) vals[i] = f_eval(tw[i], tg[i], td[i], gm_sel(m));
        expv = f_out(vals, m[1]);
        for (int i = 0; i < N; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            W = 3'(tw[i]); V_GS = 3'(tg[i]); V_DS = 3'(td[i]);
            mode = (i == 0) ? m : 2'($urandom);
            if (i == 0) chk({tag, "_pre_ov"}, int'(out_valid), 0);
            else        chk({tag, "_load_busy"}, int'(busy), 1);
        end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            in_valid = noise ? 1'($urandom) : 1'b0;
            W = 3'($urandom); V_GS = 3'($urandom); V_DS = 3'($urandom); mode = 2'($urandom);
            if (k < 3) begin
                chk({tag, "_early_ov"}, int'(out_valid), 0);
                chk({tag, "_drain_busy"}, int'(busy), 1);
            end else begin
                chk({tag, "_ov"}, int'(out_valid), 1);
                chk({tag, "_out_n"}, int'(out_n), expv);
            end
        end
        $display("group %s mode=%0d exp=%0d got=%0d", tag, m, expv, out_n);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({tag, "_idle_ov"}, int'(out_valid), 0);
            chk({tag, "_idle_n"}, int'(out_n), 0);
            chk({tag, "_idle_busy"}, int'(busy), 0);
        end
    endtask

    task automatic set_all(input int w, input int g, input int d);
        for (int i = 0; i < N; i++) begin tw[i] = w; tg[i] = g; td[i] = d; end
    endtask

    task automatic set_ramp(input bit rev);
        for (int i = 0; i < N; i++) begin
            tw[i] = rev ? N - i : i + 1; tg[i] = 4; td[i] = 7;
        end
    endtask

    initial begin
        #3;
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_n_out", int'(out_n), 0);
        chk("rst_busy", int'(busy), 0);
        #20 rst_n = 1'b1;
        idle(2, "start");

        set_all(1, 3, 1); run_group(2'b10, 1'b0, "triode1"); idle(1, "t1");
        set_all(7, 7, 7); run_group(2'b10, 1'b0, "sat84");   idle(1, "s84");
        set_ramp(1'b0);   run_group(2'b10, 1'b1, "ramp_lg"); idle(1, "r1");
        set_ramp(1'b0);   run_group(2'b00, 1'b1, "ramp_sm"); idle(1, "r2");
        set_ramp(1'b1);   run_group(2'b10, 1'b0, "rev_lg");  idle(1, "r3");
        set_ramp(1'b1);   run_group(2'b00, 1'b0, "rev_sm");  idle(1, "r4");
        set_ramp(1'b0);   run_group(2'b11, 1'b0, "ramp_gm"); idle(1, "r5");
        set_all(5, 0, 3); run_group(2'b10, 1'b0, "vgs0");    idle(1, "v0");

        // Short burst: dropped after 4 descriptors, then a full group.
        set_ramp(1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; W = 3'(tw[i]); V_GS = 3'(tg[i]); V_DS = 3'(td[i]); mode = 2'b10;
        end
        @(posedge clk); #1; in_valid = 1'b0;
        idle(N + 4, "abort");
        run_group(2'b10, 1'b0, "post_abort"); idle(1, "pa");

        // Asynchronous reset while draining.
        set_all(7, 7, 7);
        for (int i = 0; i < N; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; W = 3'(tw[i]); V_GS = 3'(tg[i]); V_DS = 3'(td[i]); mode = 2'b10;
        end
        @(posedge clk); #1; in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", int'(out_valid), 0);
        chk("arst_n", int'(out_n), 0);
        chk("arst_busy", int'(busy), 0);
        #2 rst_n = 1'b1;
        idle(N, "after_rst");
        set_ramp(1'b0); run_group(2'b00, 1'b0, "post_rst"); idle(1, "pr");

        // Back-to-back directed groups, zero gap.
        set_ramp(1'b0); run_group(2'b10, 1'b1, "b2b_a");
        set_ramp(1'b1); run_group(2'b00, 1'b1, "b2b_b");
        set_all(7, 7, 7); run_group(2'b10, 1'b0, "b2b_c");
        idle(2, "b2b");

        // Randomized groups with random gaps (0 = back-to-back).
        for (int g = 0; g < 30; g++) begin
            int gap;
            for (int i = 0; i < N; i++) begin
                tw[i] = $urandom_range(7); tg[i] = $urandom_range(7); td[i] = $urandom_range(7);
            end
            run_group(2'($urandom), 1'($urandom), $sformatf("rnd%0d", g));
            gap = $urandom_range(2);
            if (gap != 0) idle(gap, "rnd");
        end
        idle(2, "end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
